redmule_tile_sequencer: RTL
===========================

REDMULE_TILE_SEQUENCER -- requirements
Module: redmule_tile_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning width of every iteration counter and count input.
REQ-002 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: clear_i  in  1  synchronous soft clear; start_i  in  1  launch sequence (pulse).
REQ-004 SHALL have ports: x_rows_iter_i, w_cols_iter_i, x_cols_iter_i  in  CNT_W  loop bounds, sampled at start.
REQ-005 SHALL have ports: x_rows_lftovr_i, x_cols_lftovr_i, w_cols_lftovr_i  in  8  leftover sizes, sampled at start.
REQ-006 SHALL have ports: tile_valid_o  out  1; tile_ready_i  in  1  tile-issue handshake.
REQ-007 SHALL have ports: tile_row_o, tile_wcol_o, tile_xcol_o  out  CNT_W  current tile indices.
REQ-008 SHALL have ports: tile_first_o  out  1  first x_col of a Z tile; tile_last_o  out  1  last x_col of a Z tile (store).
REQ-009 SHALL have ports: row_lftovr_o, wcol_lftovr_o, xcol_lftovr_o  out  1  current tile is partial in that dimension.
REQ-010 SHALL have ports: busy_o  out  1; done_o  out  1  one-cycle completion pulse; stores_o  out  CNT_W  Z tiles issued.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 IDLE: start_i=1 samples all bound/leftover inputs into registers; all counters zeroed; next state RUN if every bound is non-zero, else DONE.
REQ-013 start_i SHALL be ignored in RUN and DONE.
REQ-014 RUN: tile_valid_o=1 combinationally from state; indices, flags stable while tile_valid_o=1 and tile_ready_i=0.
REQ-015 Handshake: tile advances only on tile_valid_o & tile_ready_i; no combinational path tile_ready_i -> tile_valid_o.
REQ-016 Loop order, innermost first: xcol, then wcol, then row; xcol wraps to 0 at bound-1 and carries into wcol; wcol wraps and carries into row.
REQ-017 tile_first_o = (xcol==0); tile_last_o = (xcol==x_cols_iter-1); both may be 1 together when x_cols_iter=1.
REQ-018 row_lftovr_o = (row==x_rows_iter-1) & (x_rows_lftovr!=0); wcol_lftovr_o and xcol_lftovr_o analogous on their dimension.
REQ-019 stores_o SHALL increment by 1 on each accepted tile with tile_last_o=1; saturates never needed (max = rows*wcols truncated to CNT_W, wraps modulo 2^CNT_W).
REQ-020 Accepted tile with row, wcol, xcol all at bound-1 SHALL transition RUN -> DONE; tile_valid_o drops the next cycle.
REQ-021 DONE: done_o=1 for exactly one cycle, then IDLE; counters hold final values until next start.
REQ-022 busy_o = (state != IDLE).
REQ-023 Zero bound at start: no tile issued, RUN skipped, done_o pulses one cycle after start, stores_o=0.
REQ-024 Tiles issued total SHALL equal x_rows_iter*w_cols_iter*x_cols_iter (product of registered bounds).
REQ-025 Input changes after start SHALL not affect the running sequence.
REQ-026 Max throughput: one tile per cycle with tile_ready_i held 1.

Reset
REQ-027 On rst_ni=0 (async) or clear_i=1 (sync, priority over start_i and handshake): state IDLE, all counters and registered bounds 0.
REQ-028 Reset values: tile_valid_o=0, tile_first_o=0, tile_last_o=0, all lftovr outputs 0, indices 0, stores_o=0, busy_o=0, done_o=0.
REQ-029 clear_i mid-RUN SHALL abort without done_o pulse; a start_i in the cycle after clear SHALL be accepted normally.

Verification
REQ-030 bounds rows=2,wcols=3,xcols=2, ready=1 -> 12 tiles in 12 consecutive cycles, order (0,0,0),(0,0,1),(0,1,0)...(1,2,1); stores_o=6; done_o one cycle after last accept.
REQ-031 rows=1,wcols=1,xcols=1, lftovr all non-zero -> single tile with first=last=1 and all three lftovr flags 1; stores_o=1.
REQ-032 xcols=0 -> no tile_valid_o, done_o pulse cycle after start, stores_o=0, busy_o high for exactly one cycle.
REQ-033 rows=1,wcols=2,xcols=3, random tile_ready_i back-pressure -> indices/flags stable during stall, 6 tiles exactly, none duplicated or dropped.
REQ-034 clear_i asserted at 3rd accepted tile of 12-tile run -> next cycle IDLE, all outputs reset values, no done_o; restart completes fully.
REQ-035 start_i pulsed during RUN with different bounds -> ignored; sequence and tile count follow original bounds.

Source files
------------

// File: rtl/redmule_tile_sequencer.sv
// -----------------------------------------------------------------------------
// redmule_tile_sequencer
//   Walks the (row, wcol, xcol) tile space of a GEMM job and issues one tile
//   per valid/ready handshake. The loop order is xcol innermost, then wcol,
//   then row. The last x_col of each Z tile is flagged as a store, and the
//   sequencer counts how many stores it issued.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous soft clear (wins over start and handshake)
//   start_i                launch pulse; only honoured in IDLE
//   *_iter_i               loop bounds, sampled at start
//   *_lftovr_i             leftover sizes; non-zero marks the last tile as partial
//   tile_valid_o/ready_i   tile-issue handshake
//   tile_row/wcol/xcol_o   indices of the current tile
//   tile_first/last_o      first / last x_col of the current Z tile
//   *_lftovr_o             current tile is partial in that dimension
//   busy_o, done_o         sequencer active / one-cycle completion pulse
//   stores_o               number of Z tiles issued (wraps modulo 2^CNT_W)
// -----------------------------------------------------------------------------
module redmule_tile_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] x_rows_iter_i,
    input  logic [CNT_W-1:0] w_cols_iter_i,
    input  logic [CNT_W-1:0] x_cols_iter_i,
    input  logic [7:0]       x_rows_lftovr_i,
    input  logic [7:0]       x_cols_lftovr_i,
    input  logic [7:0]       w_cols_lftovr_i,
    output logic             tile_valid_o,
    input  logic             tile_ready_i,
    output logic [CNT_W-1:0] tile_row_o,
    output logic [CNT_W-1:0] tile_wcol_o,
    output logic [CNT_W-1:0] tile_xcol_o,
    output logic             tile_first_o,
    output logic             tile_last_o,
    output logic             row_lftovr_o,
    output logic             wcol_lftovr_o,
    output logic             xcol_lftovr_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] stores_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] row_q, wcol_q, xcol_q;
    logic [CNT_W-1:0] rows_q, wcols_q, xcols_q;
    logic [CNT_W-1:0] stores_q;
    logic [7:0]       row_lo_q, wcol_lo_q, xcol_lo_q;

    logic run, accept, row_end, wcol_end, xcol_end;

    assign run      = (state_q == RUN);
    assign accept   = run & tile_ready_i;
    assign row_end  = (row_q  == rows_q  - CNT_W'(1));
    assign wcol_end = (wcol_q == wcols_q - CNT_W'(1));
    assign xcol_end = (xcol_q == xcols_q - CNT_W'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            row_q     <= '0;
            wcol_q    <= '0;
            xcol_q    <= '0;
            rows_q    <= '0;
            wcols_q   <= '0;
            xcols_q   <= '0;
            stores_q  <= '0;
            row_lo_q  <= '0;
            wcol_lo_q <= '0;
            xcol_lo_q <= '0;
        end else if (clear_i) begin
            state_q   <= IDLE;
            row_q     <= '0;
            wcol_q    <= '0;
            xcol_q    <= '0;
            rows_q    <= '0;
            wcols_q   <= '0;
            xcols_q   <= '0;
            stores_q  <= '0;
            row_lo_q  <= '0;
            wcol_lo_q <= '0;
            xcol_lo_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        rows_q    <= x_rows_iter_i;
                        wcols_q   <= w_cols_iter_i;
                        xcols_q   <= x_cols_iter_i;
                        row_lo_q  <= x_rows_lftovr_i;
                        wcol_lo_q <= w_cols_lftovr_i;
                        xcol_lo_q <= x_cols_lftovr_i;
                        row_q     <= '0;
                        wcol_q    <= '0;
                        xcol_q    <= '0;
                        stores_q  <= '0;
                        // An empty tile space skips RUN entirely.
                        state_q   <= (x_rows_iter_i != '0 && w_cols_iter_i != '0 &&
                                      x_cols_iter_i != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (xcol_end) stores_q <= stores_q + CNT_W'(1);
                        // The final tile leaves the indices parked at bound-1.
                        if (row_end && wcol_end && xcol_end) begin
                            state_q <= DONE;
                        end else if (!xcol_end) begin
                            xcol_q <= xcol_q + CNT_W'(1);
                        end else begin
                            xcol_q <= '0;
                            if (!wcol_end) begin
                                wcol_q <= wcol_q + CNT_W'(1);
                            end else begin
                                wcol_q <= '0;
                                row_q  <= row_q + CNT_W'(1);
                            end
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Flags are only meaningful while a tile is on offer; outside RUN they
    // read 0 so that idle/reset values are clean.
    assign tile_valid_o  = run;
    assign tile_row_o    = row_q;
    assign tile_wcol_o   = wcol_q;
    assign tile_xcol_o   = xcol_q;
    assign tile_first_o  = run & (xcol_q == '0);
    assign tile_last_o   = run & xcol_end;
    assign row_lftovr_o  = run & row_end  & (row_lo_q  != '0);
    assign wcol_lftovr_o = run & wcol_end & (wcol_lo_q != '0);
    assign xcol_lftovr_o = run & xcol_end & (xcol_lo_q != '0);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign stores_o      = stores_q;

endmodule
